// File: rtl/uart_rx_fifo.sv
// 8-bit UART receiver (optional even parity) feeding a valid/ready receive FIFO.
// Frame errors, parity errors and overruns are latched as sticky flags until clear_i or reset.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 69,
    parameter int PARITY_EN    = 0,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          rx_i,
    input  logic                          rx_en_i,
    input  logic                          clear_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overrun_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic          rx_m, rx_s, rx_q;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          par_bad;
    logic          push, frame_evt, parity_evt;
    logic          tick;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, do_push;

    // Line synchronizer plus edge-history flop; all idle high.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            {rx_m, rx_s, rx_q} <= 3'b111;
        end else begin
            {rx_m, rx_s, rx_q} <= {rx_i, rx_m, rx_s};
        end
    end

    assign tick = (cnt == '0);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            par_bad    <= 1'b0;
            push       <= 1'b0;
            frame_evt  <= 1'b0;
            parity_evt <= 1'b0;
        end else begin
            push       <= 1'b0;
            frame_evt  <= 1'b0;
            parity_evt <= 1'b0;
            if (!rx_en_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_q && !rx_s) begin
                            cnt   <= HALF_LOAD;
                            state <= START;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (!rx_s) begin
                                cnt     <= FULL_LOAD;
                                idx     <= 3'd0;
                                par_bad <= 1'b0;
                                state   <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            cnt <= FULL_LOAD;
                            idx <= idx + 3'd1;
                            if (idx == 3'd7) begin
                                state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PARITY: begin
                        if (tick) begin
                            cnt     <= FULL_LOAD;
                            par_bad <= (rx_s != ^shift);
                            state   <= STOP;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            state <= IDLE;
                            // A low stop bit outranks any parity result.
                            if (!rx_s) begin
                                frame_evt <= 1'b1;
                            end else if (par_bad) begin
                                parity_evt <= 1'b1;
                            end else begin
                                push <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Shift register holds its value through STOP and the following push cycle.
    always_ff @(posedge clk_in) begin
        if (state == DATA && tick) begin
            shift[idx] <= rx_s;
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    assign do_push = push && !clear_i && (!full || pop);
    assign count_o = wr_ptr - rd_ptr;
    assign data_o  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shift;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else if (clear_i) begin
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (frame_evt)                 frame_err_o  <= 1'b1;
            if (parity_evt)                parity_err_o <= 1'b1;
            if (push && full && !pop)      overrun_o    <= 1'b1;
        end
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synthesizable 8-bit UART receiver with a receive FIFO and sticky error flags. It consumes the SoC's `uart_tx` pad output and can run in the simulation environment or on an FPGA harness in place of the behavioural UART receive model. Received bytes are presented on a valid/ready stream so that a checker or host bridge can drain them at its own pace.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 69: clock cycles per UART bit. 8 MHz / 115200 baud ≈ 69. Minimum value is 4.
- `PARITY_EN`, default 0: 1 means an even parity bit follows the data bits.
- `FIFO_DEPTH`, default 8: number of receive FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk_in`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `rx_i`  input  1  serial line. Asynchronous to `clk_in`; idles high.
- `rx_en_i`  input  1  receiver enable. Low holds the FSM in IDLE.
- `clear_i`  input  1  synchronous pulse that flushes the FIFO and clears all sticky flags.
- `data_o`  output  8  byte at the FIFO head.
- `valid_o`  output  1  FIFO not empty.
- `ready_i`  input  1  consumer accepts `data_o` when `valid_o && ready_i`.
- `count_o`  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `frame_err_o`  output  1  sticky: stop bit sampled low.
- `parity_err_o`  output  1  sticky: parity mismatch. Always 0 when `PARITY_EN=0`.
- `overrun_o`  output  1  sticky: a byte was dropped because the FIFO was full.

## Operation

Input conditioning:
- `rx_i` passes through a 2-flop synchronizer, producing `rx_s`, followed by one history flop `rx_q` used for edge detection.

FSM states: IDLE, START, DATA, PARITY, STOP. One bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
- IDLE: on `rx_en_i && rx_q==1 && rx_s==0` (falling edge), load the counter with CLKS_PER_BIT/2 − 1 (integer division) and go to START.
- START: count down to 0, then sample `rx_s`.
  - If 0, reload the counter with CLKS_PER_BIT − 1 and go to DATA with index 0.
  - If 1, treat it as a glitch: go to IDLE with no flag set.
- DATA: at each counter expiry, sample into shift register bit `index`, LSB first. After index 7, go to PARITY if `PARITY_EN`, otherwise go to STOP. The counter reloads on every expiry.
- PARITY: at expiry, compare the sample with the XOR of the 8 data bits. Record any mismatch internally, then go to STOP.
- STOP: at expiry, sample.
  - Sample 1 and no parity mismatch: push the byte.
  - Sample 1 with a parity mismatch: set `parity_err_o` and discard the byte.
  - Sample 0: set `frame_err_o` and discard the byte, whatever the parity result.
  - In all three cases go to IDLE. A new frame requires a fresh falling edge, so a held-low break does not retrigger reception.
- `rx_en_i` low in any state returns the FSM to IDLE next cycle. The partial byte is discarded; the FIFO and flags are kept.

FIFO:
- Circular buffer with read/write pointers one bit wider than the address.
- Pop on `valid_o && ready_i`.
- Push when full: if a pop occurs in the same cycle, the push is accepted. Otherwise the new byte is dropped, `overrun_o` is set, and the FIFO contents are unchanged.
- Push while empty with `ready_i` high: the byte is stored. It is not forwarded combinationally.
- `data_o` is the FIFO head. Its value is don't-care when `valid_o=0`.

`clear_i`:
- Empties the FIFO and clears all three sticky flags.
- Does not affect the FSM; a frame in progress continues.
- If a push coincides with `clear_i`, the clear wins and the byte is dropped with no overrun flag.

Reset:
- All outputs 0: `data_o=8'h00`, `valid_o=0`, `count_o=0`, all flags 0.
- FSM returns to IDLE; synchronizer and history flops reset to 1.
- Asserting reset mid-frame aborts the frame. No byte and no flag results.

## Timing

- Reference point: E0 is the `clk_in` edge at which the first synchronizer flop captures the low `rx_i` start bit.
- `rx_s` goes low at E1. The falling edge is detected and START is entered at E2.
- Samples fall at E2 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT for k = 0 (start), 1..8 (data), 9 (parity, if enabled), then stop.
- The stop sample is at k=9, or k=10 with parity. The push occurs on that edge, so `valid_o` and `count_o` update 1 cycle later.
- Pop: `count_o` decrements and `data_o` advances on the accepting edge.
- Flags assert 1 cycle after the offending sample or push edge and stay set until `clear_i` or `reset`.

## Test plan

All scenarios use `CLKS_PER_BIT=8` and `FIFO_DEPTH=4`.
- Single byte: send 8'hA5 with `ready_i=0` → `valid_o=1`, `data_o=8'hA5`, `count_o=1`, all flags 0. Then pulse `ready_i` for 1 cycle → `valid_o=0`.
- Latency: send 8'h00 → `valid_o` rises exactly 2 + 4 + 9·8 + 1 = 79 cycles after E0.
- Overrun and simultaneous pop:
  - Send 5 bytes 8'h01..8'h05 with `ready_i=0` → `count_o=4`, `overrun_o=1`, drain order 01, 02, 03, 04.
  - Repeat with a single pop aligned to the 5th push → `overrun_o=0`, drain order 02, 03, 04, 05.
- Errors:
  - Stop bit held 0 → `frame_err_o=1`, `count_o=0`.
  - 100-cycle glitch-free break → exactly one frame error.
  - 3-cycle low glitch on idle line → no byte, no flag.
  - `PARITY_EN=1` with wrong parity on 8'h3C → `parity_err_o=1`, no byte.
  - Pulse `clear_i` → all flags 0.
- Abort:
  - Drop `rx_en_i` during data bit 3 → no byte; the next full frame 8'h7E is received correctly.
  - Assert `reset` mid-frame → all outputs 0 and the next frame is received correctly.
